io_uart_tx: RTL and testbench
=============================

IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 SHALL have parameter XLEN, default `XLEN_32b, word-width code; data and address width is W = 1<<(XLEN+4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries, power of two, at least 2.
REQ-003 SHALL have parameter BAUD_DIV_RST, default 16'd868, clocks per bit after reset.
REQ-004 SHALL have port i_clk, input, 1, single clock, all state on rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port i_io_en, input, 1, IO-region select from the address mapper.
REQ-007 SHALL have port i_lw, input, 1, load request.
REQ-008 SHALL have port i_sw, input, 1, store request.
REQ-009 SHALL have port i_addr, input, W, region-relative translated address.
REQ-010 SHALL have port i_wdata, input, W, store data.
REQ-011 SHALL have port o_rdata, output, W, registered load data.
REQ-012 SHALL have port o_tx, output, 1, serial line, idle high.
REQ-013 SHALL have port o_irq, output, 1, level interrupt.

Function
REQ-014 SHALL decode i_addr[3:2] when i_io_en=1; i_addr[1:0] is ignored; addresses >=0x10 read 0 and ignore writes.
REQ-015 SHALL treat offset 0x0 TXDATA as write-only: a store pushes i_wdata[7:0] to the FIFO, and a load returns 0.
REQ-016 SHALL return STATUS at offset 0x4 (read-only): bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[15:8] FIFO count.
REQ-017 SHALL provide BAUD_DIV at offset 0x8, read/write, bits[15:0]; a written value of 0 SHALL be treated as 1.
REQ-018 SHALL provide CTRL at offset 0xC, read/write: bit0 tx_en (reset 1), bit1 irq_en (reset 0).
REQ-019 SHALL update o_rdata on the clock edge after i_io_en & i_lw, giving 1-cycle load latency; o_rdata SHALL hold its value otherwise.
REQ-020 SHALL give i_sw priority when i_lw and i_sw are both high: the write is performed and o_rdata is unchanged.
REQ-021 SHALL drop a push while the FIFO is full unless a pop occurs in the same cycle, and SHALL set overflow on any drop.
REQ-022 SHALL clear overflow on the edge that captures a STATUS load.
REQ-023 SHALL implement the FSM states IDLE, START, DATA, STOP.
REQ-024 SHALL transition IDLE->START and pop the FIFO when tx_en=1 and the FIFO is not empty.
REQ-025 SHALL hold each bit for exactly BAUD_DIV clocks; frame is 8N1, LSB first, start bit 0, stop bit 1.
REQ-026 SHALL transition STOP->START directly when the FIFO is not empty and tx_en=1, giving back-to-back frames with no idle gap.
REQ-027 SHALL, when tx_en is cleared mid-frame, complete the current frame and then stay in IDLE.
REQ-028 SHALL apply a BAUD_DIV write made mid-frame from the next bit boundary.

Reset
REQ-029 SHALL, on i_rst_n=0 asynchronously, set: FSM to IDLE; o_tx=1; o_rdata=0; o_irq=0; FIFO empty; overflow=0; BAUD_DIV=BAUD_DIV_RST; CTRL=2'b01.
REQ-030 SHALL abort any in-flight frame on reset and lose all FIFO contents.

Configuration
REQ-031 SHALL, with IO_UART_TX_IRQ_EN defined, drive o_irq = irq_en & (empty | overflow), registered.
REQ-032 SHALL, without IO_UART_TX_IRQ_EN, tie o_irq to 0; CTRL bit1 then reads 0 and ignores writes.

Structure
REQ-033 SHALL take from shared package io_pkg: register offsets, STATUS/CTRL bit positions, and the FSM state enum.
REQ-034 SHALL instantiate one sub-module, io_sync_fifo (parameters WIDTH=8, DEPTH), with push/pop/full/empty/count outputs.

Verification
REQ-035 SHALL cover: after reset, load 0x4 -> o_rdata=0x0000_0004 one cycle later; o_tx=1.
REQ-036 SHALL cover: BAUD_DIV=4, store 0xA5 to 0x0 -> o_tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks, then idle.
REQ-037 SHALL cover: 10 stores with tx idle and tx_en=0 -> count=8, overflow=1; a second STATUS load shows overflow=0.
REQ-038 SHALL cover: two bytes queued -> the second start bit begins the clock after the first stop bit ends.
REQ-039 SHALL cover: reset asserted mid DATA bit 3 -> o_tx=1 immediately and STATUS=0x4 after release.
REQ-040 SHALL cover: IO_UART_TX_IRQ_EN defined, irq_en=1 -> o_irq=1 while empty and 0 one cycle after a push; with the macro undefined, o_irq stays 0.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: shared IO-region definitions
// register offsets, bit positions, UART TX FSM states
`ifndef XLEN_32b
`define XLEN_32b 1
`endif

package io_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  localparam int CTRL_TXEN  = 0;
  localparam int CTRL_IRQEN = 1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/io_uart_tx_if.sv
// io_uart_tx_if: IO-region load/store bus
// master drives requests, slave returns load data
interface io_uart_tx_if #(
  parameter int W = 32
);

  logic         io_en;
  logic         lw;
  logic         sw;
  logic [W-1:0] addr;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;

  modport master (
    output io_en, lw, sw, addr, wdata,
    input  rdata
  );

  modport slave (
    input  io_en, lw, sw, addr, wdata,
    output rdata
  );

endinterface

// File: rtl/io_sync_fifo.sv
// io_sync_fifo: single-clock FIFO, first-word fall-through
// a push while full is accepted only alongside a pop
module io_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  // storage array, no reset needed
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count
               + {{AW{1'b0}}, w_push}
               - {{AW{1'b0}}, w_pop};
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter
// IO_UART_TX_IRQ_EN enables the registered interrupt
`ifndef XLEN_32b
`define XLEN_32b 1
`endif

module io_uart_tx
  import io_pkg::*;
#(
  parameter  int          XLEN         = `XLEN_32b,
  parameter  int          FIFO_DEPTH   = 8,
  parameter  logic [15:0] BAUD_DIV_RST = 16'd868,
  localparam int          W            = 1 << (XLEN + 4),
  localparam int          CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_io_en,
  input  logic         i_lw,
  input  logic         i_sw,
  input  logic [W-1:0] i_addr,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic         o_tx,
  output logic         o_irq
);

  tx_state_e   r_state;
  tx_state_e   w_state_nxt;
  logic [W-1:0] r_rdata;
  logic [15:0] r_baud;
  logic [15:0] r_div;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_txen;
  logic        r_irqen;
  logic        r_ovf;
  logic        w_hit;
  logic [1:0]  w_off;
  logic        w_wr;
  logic        w_ld;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]  w_fdata;
  logic        w_bit_end;
  logic [W-1:0] w_rmux;
  logic        w_unused;

  assign w_hit  = i_io_en & (i_addr[W-1:4] == '0);
  assign w_off  = i_addr[3:2];
  assign w_wr   = w_hit & i_sw;
  assign w_ld   = i_io_en & i_lw & ~i_sw;
  assign w_push = w_wr & (w_off == OFF_TXDATA);
  assign w_bit_end = (r_cnt == r_div - 16'd1);
  assign o_rdata = r_rdata;
  assign w_unused = &{1'b0, i_addr[1:0],
                      i_wdata[W-1:16]};

  io_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata (i_wdata[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // register read mux; out-of-range reads give 0
  always_comb begin
    w_rmux = '0;
    if (w_hit) begin
      unique case (w_off)
        OFF_STATUS: begin
          w_rmux[STAT_BUSY]  = (r_state != TX_IDLE);
          w_rmux[STAT_FULL]  = w_full;
          w_rmux[STAT_EMPTY] = w_empty;
          w_rmux[STAT_OVF]   = r_ovf;
          w_rmux[15:8]       = 8'(w_count);
        end
        OFF_BAUD: w_rmux[15:0] = r_baud;
        OFF_CTRL: begin
          w_rmux[CTRL_TXEN]  = r_txen;
          w_rmux[CTRL_IRQEN] = r_irqen;
        end
        default: w_rmux = '0;
      endcase
    end
  end

  // CPU-visible registers and load data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
      r_baud  <= BAUD_DIV_RST;
      r_txen  <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      if (w_ld) r_rdata <= w_rmux;
      if (w_wr && w_off == OFF_BAUD)
        r_baud <= (i_wdata[15:0] == '0) ?
                  16'd1 : i_wdata[15:0];
      if (w_wr && w_off == OFF_CTRL)
        r_txen <= i_wdata[CTRL_TXEN];
      if (w_push && w_full && !w_pop)
        r_ovf <= 1'b1;
      else if (w_ld && w_hit && w_off == OFF_STATUS)
        r_ovf <= 1'b0;
    end
  end

`ifdef IO_UART_TX_IRQ_EN
  logic r_irq;

  // irq enable bit and registered level interrupt
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irqen <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr && w_off == OFF_CTRL)
        r_irqen <= i_wdata[CTRL_IRQEN];
      r_irq <= r_irqen & (w_empty | r_ovf);
    end
  end

  assign o_irq = r_irq;
`else
  assign r_irqen = 1'b0;
  assign o_irq   = 1'b0;
`endif

  // next state and FIFO pop at frame boundaries
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    unique case (r_state)
      TX_IDLE: begin
        if (r_txen && !w_empty) begin
          w_state_nxt = TX_START;
          w_pop       = 1'b1;
        end
      end
      TX_START: begin
        if (w_bit_end) w_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        if (w_bit_end && r_idx == 3'd7)
          w_state_nxt = TX_STOP;
      end
      TX_STOP: begin
        if (w_bit_end) begin
          if (r_txen && !w_empty) begin
            w_state_nxt = TX_START;
            w_pop       = 1'b1;
          end else begin
            w_state_nxt = TX_IDLE;
          end
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= TX_IDLE;
    else          r_state <= w_state_nxt;
  end

  // bit timer; divisor re-sampled at each bit edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_div   <= BAUD_DIV_RST;
      r_idx   <= '0;
      r_shift <= '0;
    end else if (w_pop) begin
      r_cnt   <= '0;
      r_div   <= r_baud;
      r_idx   <= '0;
      r_shift <= w_fdata;
    end else if (r_state != TX_IDLE) begin
      if (w_bit_end) begin
        r_cnt <= '0;
        r_div <= r_baud;
        if (r_state == TX_DATA) begin
          r_shift <= r_shift >> 1;
          r_idx   <= r_idx + 3'd1;
        end
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // serial line level from the current bit
  always_comb begin
    o_tx = 1'b1;
    unique case (r_state)
      TX_START: o_tx = 1'b0;
      TX_DATA:  o_tx = r_shift[0];
      default:  o_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: directed plus random checks
// against a queue-based line/FIFO model
module tb_io_uart_tx;

  localparam int W     = 32;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic o_tx;
  logic o_irq;

  io_uart_tx_if #(.W(W)) bus ();

  io_uart_tx #(
    .XLEN         (1),
    .FIFO_DEPTH   (DEPTH),
    .BAUD_DIV_RST (16'd868)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_io_en (bus.io_en),
    .i_lw    (bus.lw),
    .i_sw    (bus.sw),
    .i_addr  (bus.addr),
    .i_wdata (bus.wdata),
    .o_rdata (bus.rdata),
    .o_tx    (o_tx),
    .o_irq   (o_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                 nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  fq[$];
  bit          bq[$];
  int          rem;
  int          m_baud;
  bit          m_txen, m_irqen, m_ovf, m_irq;
  logic [31:0] m_rdata;

  function automatic logic [31:0] m_read(logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (a < 32'h10) begin
      case (a[3:2])
        2'd1: begin
          v[0]    = (bq.size() != 0);
          v[1]    = (fq.size() == DEPTH);
          v[2]    = (fq.size() == 0);
          v[3]    = m_ovf;
          v[15:8] = 8'(fq.size());
        end
        2'd2: v = m_baud;
        2'd3: v = {30'h0, m_irqen, m_txen};
        default: v = 32'h0;
      endcase
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      bq.delete();
      rem = 0; m_baud = 868; m_txen = 1;
      m_irqen = 0; m_ovf = 0; m_irq = 0;
      m_rdata = 0;
    end else begin : step
      logic [31:0] rv;
      logic [7:0]  b;
      bit          st;
      rv = m_read(bus.addr);
      m_irq = m_irqen & ((fq.size() == 0) | m_ovf);
      st = 0;
      if (bq.size() != 0) begin
        rem--;
        if (rem == 0) begin
          void'(bq.pop_front());
          if (bq.size() != 0) rem = m_baud;
          else st = 1;
        end
      end else st = 1;
      if (st && m_txen && fq.size() != 0) begin
        b = fq.pop_front();
        bq.push_back(1'b0);
        for (int i = 0; i < 8; i++) bq.push_back(b[i]);
        bq.push_back(1'b1);
        rem = m_baud;
      end
      if (bus.io_en && bus.sw) begin
        if (bus.addr < 32'h10) begin
          case (bus.addr[3:2])
            2'd0: if (fq.size() < DEPTH)
                    fq.push_back(bus.wdata[7:0]);
                  else m_ovf = 1;
            2'd2: m_baud = (bus.wdata[15:0] == 0) ?
                           1 : int'(bus.wdata[15:0]);
            2'd3: begin
              m_txen = bus.wdata[0];
`ifdef IO_UART_TX_IRQ_EN
              m_irqen = bus.wdata[1];
`endif
            end
            default: ;
          endcase
        end
      end else if (bus.io_en && bus.lw) begin
        m_rdata = rv;
        if (bus.addr < 32'h10 && bus.addr[3:2] == 2'd1)
          m_ovf = 0;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("tx_model", {31'h0, o_tx},
          {31'h0, (bq.size() != 0) ? bq[0] : 1'b1});
      chk("rdata_model", bus.rdata, m_rdata);
      chk("irq_model", {31'h0, o_irq}, {31'h0, m_irq});
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    @(negedge clk);
    bus.io_en = 1; bus.sw = 1; bus.lw = 0;
    bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.io_en = 0; bus.sw = 0;
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] d);
    @(negedge clk);
    bus.io_en = 1; bus.lw = 1; bus.sw = 0;
    bus.addr = a;
    @(negedge clk);
    bus.io_en = 0; bus.lw = 0;
    d = bus.rdata;
  endtask

  task automatic wait_fall(input string nm,
                           output int n);
    logic p;
    n = 0;
    p = o_tx;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (p && !o_tx) break;
      p = o_tx;
    end
    if (n >= 300) chk({nm, "_timeout"}, 32'(n), 0);
  endtask

  logic [31:0] v;
  logic [9:0]  pat;
  int          n;
  int          k;

  initial begin
    bus.io_en = 0; bus.lw = 0; bus.sw = 0;
    bus.addr = 0; bus.wdata = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("reset_tx", {31'h0, o_tx}, 32'h1);
    chk("reset_rdata", bus.rdata, 32'h0);
    rd(32'h4, v);  chk("reset_status", v, 32'h4);
    rd(32'h8, v);  chk("reset_baud", v, 32'd868);
    rd(32'hC, v);  chk("reset_ctrl", v, 32'h1);
    rd(32'h14, v); chk("oob_read", v, 32'h0);
    wr(32'h18, 32'h7); rd(32'h8, v);
    chk("oob_write_ignored", v, 32'd868);
    wr(32'h8, 32'h0); rd(32'h8, v);
    chk("baud_zero_as_one", v, 32'h1);
    wr(32'hB, 32'h4); rd(32'h8, v);
    chk("baud_4", v, 32'h4);

    // 0xA5 frame at 4 clocks per bit
    pat = 10'b1101001010;
    wr(32'h0, 32'hA5);
    n = 0;
    while (o_tx && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("start_latency", 32'(n), 32'd1);
    for (int i = 0; i < 40; i++) begin
      chk("a5_bit", {31'h0, o_tx},
          {31'h0, pat[i/4]});
      @(negedge clk);
    end
    chk("a5_idle", {31'h0, o_tx}, 32'h1);
    rd(32'h4, v); chk("a5_status_idle", v, 32'h4);

    // overflow with transmitter disabled
    wr(32'hC, 32'h0);
    for (int i = 0; i < 10; i++) wr(32'h0, 32'hFF);
    rd(32'h4, v); chk("ovf_status", v, 32'h80A);
    rd(32'h4, v); chk("ovf_cleared", v, 32'h802);

    // back-to-back frames, 0xFF has one falling edge
    wr(32'h8, 32'h2);
    wr(32'hC, 32'h1);
    wait_fall("b2b0", n); chk("b2b_first", 32'(n), 32'd1);
    wait_fall("b2b1", n); chk("b2b_gap1", 32'(n), 32'd20);
    wait_fall("b2b2", n); chk("b2b_gap2", 32'(n), 32'd20);
    repeat (200) @(negedge clk);
    rd(32'h4, v); chk("drained", v, 32'h4);

    // reset in the middle of data bit 3
    wr(32'h8, 32'h4);
    wr(32'h0, 32'h00);
    wait_fall("rst_frame", n);
    repeat (17) @(negedge clk);
    chk("mid_bit3_low", {31'h0, o_tx}, 32'h0);
    #1 rst_n = 0;
    #1 chk("reset_tx_now", {31'h0, o_tx}, 32'h1);
    @(negedge clk);
    rst_n = 1;
    rd(32'h4, v); chk("status_after_rst", v, 32'h4);
    rd(32'h8, v); chk("baud_after_rst", v, 32'd868);
    wr(32'h8, 32'h3);

`ifdef IO_UART_TX_IRQ_EN
    wr(32'hC, 32'h2);
    rd(32'hC, v); chk("ctrl_irq_en", v, 32'h2);
    repeat (2) @(negedge clk);
    chk("irq_empty", {31'h0, o_irq}, 32'h1);
    wr(32'h0, 32'h11);
    @(negedge clk);
    chk("irq_after_push", {31'h0, o_irq}, 32'h0);
    wr(32'hC, 32'h3);
`else
    wr(32'hC, 32'h3);
    rd(32'hC, v); chk("ctrl_irq_masked", v, 32'h1);
    repeat (3) @(negedge clk);
    chk("irq_tied_low", {31'h0, o_irq}, 32'h0);
`endif

    // random traffic, model checks every cycle
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      k = $urandom_range(0, 19);
      bus.io_en = ($urandom_range(0, 15) != 0);
      bus.lw = 0; bus.sw = 0;
      bus.addr  = {$urandom_range(0, 3), 2'b00}
                | $urandom_range(0, 3);
      bus.wdata = $urandom;
      if (k < 6) begin
        bus.io_en = 0;
      end else if (k < 10) begin
        bus.lw = 1;
        if (k == 9) bus.addr = bus.addr | 32'h10;
      end else if (k < 13) begin
        bus.sw = 1;
        bus.addr = {30'h0, 2'b00};
      end else if (k == 13) begin
        bus.sw = 1;
        bus.addr = 32'h8;
        bus.wdata = $urandom_range(0, 3);
      end else if (k == 14) begin
        bus.sw = 1;
        bus.addr = 32'hC;
        bus.wdata = ($urandom_range(0, 3) == 0) ?
                    32'h2 : 32'h3;
      end else if (k == 15) begin
        bus.sw = 1; bus.lw = 1;
      end else if (k == 16) begin
        bus.sw = 1;
        bus.addr = 32'h100 | bus.addr;
      end
    end
    @(negedge clk);
    bus.io_en = 0; bus.lw = 0; bus.sw = 0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
